// File: rtl/systolic_ctrl.sv
// systolic_ctrl: sequencer for an external DIM x DIM output-stationary
// systolic array. It clears or keeps the array's C tile, feeds DIM operand
// steps through triangular skew lines, drains the pipeline with zeros, then
// hands the C rows out one at a time over a valid/ready handshake.
//
// Ports
//   clk, rst            clock and asynchronous active-high reset
//   start, acc          begin a tile (sampled in IDLE); acc=1 keeps old C
//   in_valid/in_ready   operand-step handshake; a_in = A column, b_in = B row
//   arr_en, arr_wren    array advance/MAC enable and C-row write enable
//   arr_crow            array C row select (clear and read-out)
//   arr_a, arr_b        skewed operands to array rows / columns
//   arr_cin, arr_cout   C write data (always zero) and selected C row
//   out_valid/out_ready result-row handshake; out_row / c_out row index/data
//   busy, done          not-IDLE flag and one-cycle completion pulse
module systolic_ctrl #(
  parameter int DIM     = 8,
  parameter int BITS_AB = 8,
  parameter int BITS_C  = 16
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             start,
  input  logic                             acc,
  input  logic                             in_valid,
  output logic                             in_ready,
  input  logic [DIM-1:0][BITS_AB-1:0]      a_in,
  input  logic [DIM-1:0][BITS_AB-1:0]      b_in,
  output logic                             arr_en,
  output logic                             arr_wren,
  output logic [$clog2(DIM)-1:0]           arr_crow,
  output logic [DIM-1:0][BITS_AB-1:0]      arr_a,
  output logic [DIM-1:0][BITS_AB-1:0]      arr_b,
  output logic [DIM-1:0][BITS_C-1:0]       arr_cin,
  input  logic [DIM-1:0][BITS_C-1:0]       arr_cout,
  output logic                             out_valid,
  input  logic                             out_ready,
  output logic [$clog2(DIM)-1:0]           out_row,
  output logic [DIM-1:0][BITS_C-1:0]       c_out,
  output logic                             busy,
  output logic                             done
);

  localparam int CW = $clog2(3*DIM);
  localparam int RW = $clog2(DIM);
  localparam logic [CW-1:0] ROW_LAST   = CW'(DIM-1);
  localparam logic [CW-1:0] DRAIN_LAST = CW'(2*DIM-3);

  typedef enum logic [2:0] {IDLE, CLEAR, FEED, DRAIN, READ} state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            done_q, done_d;

  // One shared counter: clear row, feed step, drain cycle, read row.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    done_d    = 1'b0;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    arr_en    = 1'b0;
    arr_wren  = 1'b0;
    arr_crow  = '0;
    case (state_q)
      IDLE: begin
        if (start) begin
          cnt_d   = '0;
          state_d = acc ? FEED : CLEAR;
        end
      end
      CLEAR: begin
        arr_wren = 1'b1;
        arr_crow = cnt_q[RW-1:0];
        if (cnt_q == ROW_LAST) begin
          cnt_d   = '0;
          state_d = FEED;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      FEED: begin
        in_ready = 1'b1;
        arr_en   = in_valid;
        if (in_valid) begin
          if (cnt_q == ROW_LAST) begin
            cnt_d   = '0;
            state_d = DRAIN;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
      end
      DRAIN: begin
        // Enough zero advances for the last skewed operand to reach PE(DIM-1,DIM-1).
        arr_en = 1'b1;
        if (cnt_q == DRAIN_LAST) begin
          cnt_d   = '0;
          state_d = READ;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      READ: begin
        out_valid = 1'b1;
        arr_crow  = cnt_q[RW-1:0];
        if (out_ready) begin
          if (cnt_q == ROW_LAST) begin
            cnt_d   = '0;
            done_d  = 1'b1;
            state_d = IDLE;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
    end
  end

  // Operands enter the skew lines only while feeding; DRAIN pushes zeros.
  logic [DIM-1:0][BITS_AB-1:0] feed_a, feed_b;
  assign feed_a = (state_q == FEED) ? a_in : '0;
  assign feed_b = (state_q == FEED) ? b_in : '0;

  assign arr_a[0] = feed_a[0];
  assign arr_b[0] = feed_b[0];

  // Lane i carries an i-deep shift line so that step k reaches lane i at
  // advance k+i; the lines move only on array advances.
  for (genvar i = 1; i < DIM; i++) begin : g_lane
    logic signed [BITS_AB-1:0] a_dly_q [i];
    logic signed [BITS_AB-1:0] a_dly_d [i];
    logic signed [BITS_AB-1:0] b_dly_q [i];
    logic signed [BITS_AB-1:0] b_dly_d [i];

    always_comb begin
      a_dly_d = a_dly_q;
      b_dly_d = b_dly_q;
      if (arr_en) begin
        a_dly_d[0] = feed_a[i];
        b_dly_d[0] = feed_b[i];
        for (int s = 1; s < i; s++) begin
          a_dly_d[s] = a_dly_q[s-1];
          b_dly_d[s] = b_dly_q[s-1];
        end
      end
    end

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        a_dly_q <= '{default: '0};
        b_dly_q <= '{default: '0};
      end else begin
        a_dly_q <= a_dly_d;
        b_dly_q <= b_dly_d;
      end
    end

    assign arr_a[i] = a_dly_q[i-1];
    assign arr_b[i] = b_dly_q[i-1];
  end

  assign arr_cin = '0;
  assign out_row = arr_crow;
  assign c_out   = arr_cout;
  assign busy    = (state_q != IDLE);
  assign done    = done_q;

endmodule
